// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD types and constants for bin2bcd_seq and the Excess-3 converter
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] ADJ_THRESH  = 4'd5;
    localparam logic [3:0] ADJ_ADD     = 4'd3;
    localparam logic [3:0] BCD_NINE    = 4'd9;
    localparam logic [3:0] EX3_OFFSET  = 4'd3;

    // Used by the downstream 8421 -> Excess-3 converter.
    function automatic logic [3:0] bcd_to_ex3(input logic [3:0] digit);
        return digit + EX3_OFFSET;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - combinational double-dabble digit correction (add 3 if >= 5)
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adj
);

    // 4-bit wrap is intentional: a corrected digit never exceeds 12.
    assign adj = (digit >= ADJ_THRESH) ? (digit + ADJ_ADD) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential binary to BCD converter, one bit per clock; BIN2BCD_SAT_EN saturates on overflow
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          ovf
);

    localparam int               BCD_W    = BCD_DIGIT_W * DIGITS;
    localparam int               CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t           state, state_nxt;
    logic [BCD_W-1:0] scratch, scratch_nxt, adj;
    logic [BCD_W-1:0] bcd_nxt;
    logic [BIN_W-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ovf_int, ovf_int_nxt;
    logic             busy_nxt, done_nxt, ovf_nxt;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (scratch[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .adj   (adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            scratch <= '0;
            shreg   <= '0;
            cnt     <= '0;
            ovf_int <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            scratch <= scratch_nxt;
            shreg   <= shreg_nxt;
            cnt     <= cnt_nxt;
            ovf_int <= ovf_int_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            bcd_out <= bcd_nxt;
            ovf     <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        scratch_nxt = scratch;
        shreg_nxt   = shreg;
        cnt_nxt     = cnt;
        ovf_int_nxt = ovf_int;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        bcd_nxt     = bcd_out;
        ovf_nxt     = ovf;

        case (state)
            IDLE: begin
                if (start) begin
                    shreg_nxt   = bin_in;
                    scratch_nxt = '0;
                    cnt_nxt     = '0;
                    ovf_int_nxt = 1'b0;
                    busy_nxt    = 1'b1;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                // The adjusted top-digit MSB falls off here; that is exactly the overflow carry.
                {scratch_nxt, shreg_nxt} = {adj[BCD_W-2:0], shreg, 1'b0};
                ovf_int_nxt = ovf_int | adj[BCD_W-1];
                cnt_nxt     = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
`ifdef BIN2BCD_SAT_EN
                bcd_nxt  = ovf_int ? {DIGITS{BCD_NINE}} : scratch;
`else
                bcd_nxt  = scratch;
`endif
                ovf_nxt   = ovf_int;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed and random checks of bin2bcd_seq at DIGITS=3 and DIGITS=2
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;

    int total = 0;
    int bad   = 0;

`ifdef BIN2BCD_SAT_EN
    localparam logic [7:0] E2_255 = 8'h99;
    localparam logic [7:0] E2_200 = 8'h99;
    localparam logic [7:0] E2_100 = 8'h99;
    localparam logic [7:0] E2_128 = 8'h99;
`else
    localparam logic [7:0] E2_255 = 8'h55;
    localparam logic [7:0] E2_200 = 8'h00;
    localparam logic [7:0] E2_100 = 8'h00;
    localparam logic [7:0] E2_128 = 8'h28;
`endif

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy3),
        .done    (done3),
        .bcd_out (bcd3),
        .ovf     (ovf3)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy2),
        .done    (done2),
        .bcd_out (bcd2),
        .ovf     (ovf2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic conv(input logic [7:0] v, input logic [11:0] e3, input logic [7:0] e2,
                        input logic eo2, input bit poke);
        logic [11:0] prev;
        int          edges;
        int          busy_n;
        bit          stable;
        @(negedge clk);
        prev   = bcd3;
        bin_in = v;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bin_in = ~v;
        edges  = 1;
        busy_n = 0;
        stable = 1'b1;
        while (!done3 && edges < 40) begin
            if (busy3) busy_n++;
            if (bcd3 !== prev) stable = 1'b0;
            if (poke && edges == 3) begin
                start  = 1'b1;
                bin_in = 8'd77;
            end else if (poke && edges == 4) begin
                start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        check("latency", edges - 1, 9);
        check("busy_cycles", busy_n, 9);
        check("hold_stable", stable, 1);
        check("done3", done3, 1);
        check("busy_at_done", busy3, 0);
        check("bcd3", bcd3, e3);
        check("ovf3", ovf3, 0);
        check("done2", done2, 1);
        check("bcd2", bcd2, e2);
        check("ovf2", ovf2, eo2);
        @(negedge clk);
        check("done_pulse", done3, 0);
        check("idle_after", busy3, 0);
        check("bcd3_held", bcd3, e3);
    endtask

    initial begin
        int n_done;
        logic [7:0]  v;
        logic [11:0] m3;
        logic [7:0]  m2;
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy3, 0);
        check("rst_done", done3, 0);
        check("rst_bcd", bcd3, 0);
        check("rst_ovf", ovf3, 0);
        rst = 1'b0;

        conv(8'd0,   12'h000, 8'h00,  1'b0, 1'b0);
        conv(8'd255, 12'h255, E2_255, 1'b1, 1'b0);
        check("ex3_d2", bcd3[11:8] + 4'd3, 4'b0101);
        check("ex3_d1", bcd3[7:4]  + 4'd3, 4'b1000);
        check("ex3_d0", bcd3[3:0]  + 4'd3, 4'b1000);
        conv(8'd99,  12'h099, 8'h99,  1'b0, 1'b0);
        conv(8'd10,  12'h010, 8'h10,  1'b0, 1'b1);
        conv(8'd200, 12'h200, E2_200, 1'b1, 1'b0);
        conv(8'd100, 12'h100, E2_100, 1'b1, 1'b0);

        // start held high: one result every 10 cycles
        start  = 1'b1;
        bin_in = 8'd37;
        n_done = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done3) begin
                n_done++;
                check("hold_bcd", bcd3, 12'h037);
                check("hold_period", i % 10, 0);
            end
        end
        start = 1'b0;
        check("hold_dones", n_done, 4);
        repeat (2) @(negedge clk);
        check("hold_idle", busy3, 0);

        // reset during the 4th SHIFT cycle of a 255 conversion
        bin_in = 8'd255;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy3, 0);
        check("abort_done", done3, 0);
        check("abort_bcd", bcd3, 0);
        check("abort_ovf", ovf3, 0);
        check("abort_bcd2", bcd2, 0);
        rst    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done3) n_done++;
        end
        check("abort_no_done", n_done, 0);
        conv(8'd128, 12'h128, E2_128, 1'b1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            v  = 8'($urandom_range(0, 255));
            m3 = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
`ifdef BIN2BCD_SAT_EN
            m2 = (v >= 100) ? 8'h99 : {4'((v / 10) % 10), 4'(v % 10)};
`else
            m2 = {4'((v / 10) % 10), 4'(v % 10)};
`endif
            conv(v, m3, m2, (v >= 100), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
